// File: rtl/modexp_word_port.sv
// Word-serial operand loader and result streamer for a modexp engine.
// Assembles five W-bit operands from DATA_WIDTH words, then drains the result.
module modexp_word_port #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            m_buf,
  input  logic [DATA_WIDTH-1:0]            e_buf,
  input  logic [DATA_WIDTH-1:0]            n_buf,
  input  logic [DATA_WIDTH-1:0]            r_buf,
  input  logic [DATA_WIDTH-1:0]            t_buf,
  input  logic [63:0]                      nprime0,
  input  logic                             start_input,
  input  logic                             start_compute,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  res_in,
  input  logic                             res_valid,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  m_op,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  e_op,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  n_op,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  r_op,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  t_op,
  output logic [63:0]                      nprime_op,
  output logic                             op_start,
  output logic [4:0]                       exp_state,
  output logic [DATA_WIDTH-1:0]            res_out
);

  localparam int W  = DATA_WIDTH * NUM_WORDS;
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CW = IW + 1;

  typedef enum logic [4:0] {
    S_IDLE     = 5'd0,
    S_LOAD     = 5'd1,
    S_READY    = 5'd2,
    S_BUSY     = 5'd3,
    S_COMPLETE = 5'd9,
    S_DRAIN    = 5'd10
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   w_idx;
  logic            r_start_d;
  logic            r_armed;
  logic            w_rise;
  logic            w_last;
  logic            w_drain_done;
  logic            w_op_start;
  logic [W-1:0]    r_m_op;
  logic [W-1:0]    r_e_op;
  logic [W-1:0]    r_n_op;
  logic [W-1:0]    r_r_op;
  logic [W-1:0]    r_t_op;
  logic [63:0]     r_nprime;
  logic [W-1:0]    r_res;
  logic [DATA_WIDTH-1:0] r_res_out;

  // r_armed masks the first cycle after reset so a level already high is no edge
  assign w_rise       = start_input & ~r_start_d & r_armed;
  assign w_idx        = r_cnt[IW-1:0];
  assign w_last       = (r_cnt == CW'(NUM_WORDS - 1));
  assign w_drain_done = (r_cnt == CW'(NUM_WORDS));

  assign m_op      = r_m_op;
  assign e_op      = r_e_op;
  assign n_op      = r_n_op;
  assign r_op      = r_r_op;
  assign t_op      = r_t_op;
  assign nprime_op = r_nprime;
  assign op_start  = w_op_start;
  assign exp_state = r_state;
  assign res_out   = r_res_out;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state and launch pulse
  always_comb begin
    w_next     = r_state;
    w_op_start = 1'b0;
    unique case (r_state)
      S_IDLE:     if (w_rise) w_next = S_LOAD;
      S_LOAD:     if (w_last) w_next = S_READY;
      S_READY: begin
        if (start_compute) begin
          w_op_start = 1'b1;
          w_next     = S_BUSY;
        end
      end
      S_BUSY:     if (res_valid) w_next = S_COMPLETE;
      S_COMPLETE: w_next = S_DRAIN;
      S_DRAIN:    if (w_drain_done) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // operand capture, result latch, word counter and result streaming
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_d <= 1'b0;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_m_op    <= '0;
      r_e_op    <= '0;
      r_n_op    <= '0;
      r_r_op    <= '0;
      r_t_op    <= '0;
      r_nprime  <= '0;
      r_res     <= '0;
      r_res_out <= '0;
    end else begin
      r_start_d <= start_input;
      r_armed   <= 1'b1;
      case (r_state)
        S_IDLE: r_cnt <= '0;
        S_LOAD: begin
          r_m_op[w_idx*DATA_WIDTH +: DATA_WIDTH] <= m_buf;
          r_e_op[w_idx*DATA_WIDTH +: DATA_WIDTH] <= e_buf;
          r_n_op[w_idx*DATA_WIDTH +: DATA_WIDTH] <= n_buf;
          r_r_op[w_idx*DATA_WIDTH +: DATA_WIDTH] <= r_buf;
          r_t_op[w_idx*DATA_WIDTH +: DATA_WIDTH] <= t_buf;
          if (w_last) begin
            r_nprime <= nprime0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BUSY: if (res_valid) r_res <= res_in;
        S_COMPLETE: begin
          r_cnt     <= '0;
          r_res_out <= '0;
        end
        // counter runs one past the last word to give the trailing zero cycle
        S_DRAIN: begin
          if (w_drain_done) begin
            r_res_out <= '0;
            r_cnt     <= '0;
          end else begin
            r_res_out <= r_res[w_idx*DATA_WIDTH +: DATA_WIDTH];
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_word_port.sv
// Bench for modexp_word_port: table of load/launch/drain vectors,
// result words checked through a scoreboard queue, plus reset corner cases.
module tb_modexp_word_port;

  localparam int DW = 64;
  localparam int NW = 64;
  localparam int W  = DW * NW;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf;
  logic [63:0]   nprime0;
  logic          start_input, start_compute;
  logic [W-1:0]  res_in;
  logic          res_valid;
  logic [W-1:0]  m_op, e_op, n_op, r_op, t_op;
  logic [63:0]   nprime_op;
  logic          op_start;
  logic [4:0]    exp_state;
  logic [DW-1:0] res_out;

  modexp_word_port #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset),
    .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf),
    .r_buf(r_buf), .t_buf(t_buf),
    .nprime0(nprime0),
    .start_input(start_input), .start_compute(start_compute),
    .res_in(res_in), .res_valid(res_valid),
    .m_op(m_op), .e_op(e_op), .n_op(n_op),
    .r_op(r_op), .t_op(t_op),
    .nprime_op(nprime_op), .op_start(op_start),
    .exp_state(exp_state), .res_out(res_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] sb[$];
  logic [W-1:0]  x_m, x_e, x_n, x_r, x_t;
  logic [63:0]   x_np;

  typedef struct {
    logic [63:0] mb;
    logic [63:0] nb;
    logic [63:0] np;
    logic [63:0] tag;
    logic [63:0] exp_m63;
    bit          ign;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    int bi;
    total++;
    if (act !== exp) begin
      bad++;
      bi = 0;
      for (int i = NW - 1; i >= 0; i--)
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) bi = i;
      $display("FAIL %s word=%0d act=%0h exp=%0h", nm, bi,
               act[bi*DW +: DW], exp[bi*DW +: DW]);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_ops(input string nm);
    chk_w({nm, "_m"}, m_op, x_m);
    chk_w({nm, "_e"}, e_op, x_e);
    chk_w({nm, "_n"}, n_op, x_n);
    chk_w({nm, "_r"}, r_op, x_r);
    chk_w({nm, "_t"}, t_op, x_t);
    chk({nm, "_np"}, nprime_op, x_np);
  endtask

  // caller is at the negedge of cycle E, IDLE, start_input low before
  task automatic do_load(input logic [63:0] mb, input logic [63:0] nb,
                         input logic [63:0] np, input int abort_at);
    chk("idle_at_E", 64'(exp_state), 64'd0);
    start_input = 1'b1;
    nprime0     = np;
    for (int k = 0; k < NW; k++) begin
      cyc();
      if (k == 0) chk("load_state", 64'(exp_state), 64'd1);
      if (k == NW / 2) chk("res_quiet_load", res_out, 64'd0);
      m_buf = mb + 64'(k);
      e_buf = (k == 0) ? 64'h10000 : 64'd0;
      n_buf = nb + 64'(k);
      r_buf = mb ^ (64'(k) << 8);
      t_buf = ~(mb + 64'(k));
      if (k == abort_at) begin
        #2 reset = 1'b0;
        #1;
        x_m = '0; x_e = '0; x_n = '0; x_r = '0; x_t = '0; x_np = '0;
        chk("rst_async_state", 64'(exp_state), 64'd0);
        chk("rst_async_res", res_out, 64'd0);
        chk("rst_async_opst", 64'(op_start), 64'd0);
        chk_ops("rst_async");
        return;
      end
      x_m[k*DW +: DW] = m_buf;
      x_e[k*DW +: DW] = e_buf;
      x_n[k*DW +: DW] = n_buf;
      x_r[k*DW +: DW] = r_buf;
      x_t[k*DW +: DW] = t_buf;
    end
    x_np = np;
    cyc();
    start_input = 1'b0;
    m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0;
    chk("ready_at_E65", 64'(exp_state), 64'd2);
    chk_ops("load");
  endtask

  // at a negedge in READY; start_compute held high for several cycles
  task automatic launch();
    int pulses;
    start_compute = 1'b1;
    #1 chk("op_start_pulse", 64'(op_start), 64'd1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (op_start) pulses++;
      chk("busy_state", 64'(exp_state), 64'd3);
    end
    chk("no_second_pulse", 64'(pulses), 64'd0);
    start_compute = 1'b0;
  endtask

  // at a negedge in BUSY (cycle B)
  task automatic drain(input logic [63:0] tag);
    logic [DW-1:0] w;
    res_valid = 1'b1;
    for (int k = 0; k < NW; k++) begin
      w = tag | 64'(k);
      res_in[k*DW +: DW] = w;
      sb.push_back(w);
    end
    cyc();
    res_valid = 1'b0;
    res_in    = '0;
    chk("complete_B1", 64'(exp_state), 64'd9);
    chk("res_zero_B1", res_out, 64'd0);
    cyc();
    chk("drain_B2", 64'(exp_state), 64'd10);
    chk("res_zero_B2", res_out, 64'd0);
    for (int k = 0; k < NW; k++) begin
      cyc();
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow word=%0d", k);
      end else begin
        w = sb.pop_front();
        chk($sformatf("res_word%0d", k), res_out, w);
      end
    end
    cyc();
    chk("res_zero_B67", res_out, 64'd0);
    chk("idle_B67", 64'(exp_state), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{64'd1, 64'hFFFF_0000, 64'h0123_4567_89AB_CDEF,
                64'hA5A5_0000_0000_0000, 64'd64, 1'b1};
    vecs[1] = '{64'd100, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h5A5A_0000_0000_0000, 64'd163, 1'b0};
    vecs[2] = '{64'h1000, 64'hDEAD_0000, 64'h1,
                64'hC3C3_0000_0000_0000, 64'h103F, 1'b0};

    reset = 1'b0;
    m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0;
    nprime0 = '0; start_input = 1'b0; start_compute = 1'b0;
    res_in = '0; res_valid = 1'b0;
    x_m = '0; x_e = '0; x_n = '0; x_r = '0; x_t = '0; x_np = '0;
    cyc(); cyc();
    chk("rst_state", 64'(exp_state), 64'd0);
    chk("rst_res", res_out, 64'd0);
    chk("rst_opst", 64'(op_start), 64'd0);
    chk_ops("rst");
    reset = 1'b1;
    cyc(); cyc();

    foreach (vecs[i]) begin
      do_load(vecs[i].mb, vecs[i].nb, vecs[i].np, -1);
      chk("m_op_w63", m_op[63*DW +: DW], vecs[i].exp_m63);
      if (vecs[i].ign) begin
        res_valid = 1'b1;
        res_in    = {W{1'b1}};
        cyc();
        res_valid = 1'b0;
        res_in    = '0;
        chk("ign_rv_ready", 64'(exp_state), 64'd2);
      end
      launch();
      if (vecs[i].ign) begin
        start_input = 1'b1;
        cyc();
        chk("ign_start_busy", 64'(exp_state), 64'd3);
        start_input = 1'b0;
        cyc();
        chk("ign_start_busy2", 64'(exp_state), 64'd3);
        chk_ops("ign_busy");
      end
      drain(vecs[i].tag);
    end

    cyc();
    do_load(64'd7, 64'h77, 64'h99, 20);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no_edge_after_rst", 64'(exp_state), 64'd0);
    end
    start_input = 1'b0;
    cyc();
    cyc();
    do_load(64'd500, 64'h3_0000, 64'h55, -1);
    launch();
    drain(64'h1111_0000_0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
